// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing for the FIFO write-side arbiter.
// The FIFO is a 32-slot ring that keeps one slot empty, so 31 entries are usable.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int FIFO_DEPTH = 32;
  localparam int CAPACITY   = FIFO_DEPTH - 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the first active request strictly after last_winner, wrapping around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_winner,
  output logic [NREQ-1:0] win,
  output logic            any
);

  logic [OW-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    // Offset NREQ comes back to last_winner itself, so it has the lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      idx = OW'((int'(last_winner) + k) % NREQ);
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side controller for the shared 32-entry FIFO.
// Grants bursts of up to MAX_BURST beats, gates reads and tracks occupancy.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int CAPACITY  = fifo_arb_pkg::CAPACITY,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*DW-1:0]             wdata,
  output logic [NREQ-1:0]                gnt,
  output logic                           ack,
  input  logic                           rd_req,
  output logic                           rd_ack,
  output logic                           fifo_w,
  output logic [DW-1:0]                  fifo_din,
  output logic                           fifo_r,
  output logic [fifo_arb_pkg::CNT_W-1:0] count,
  output logic                           full,
  output logic                           empty
);

  import fifo_arb_pkg::*;

  localparam int OW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int CW = CNT_W;

  arb_state_t      state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [OW-1:0]   owner_reg, owner_next;
  logic [OW-1:0]   last_winner_reg, last_winner_next;
  logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CW-1:0]   count_reg, count_next;

  logic [NREQ-1:0] win;
  logic            any;
  logic [OW-1:0]   win_idx;
  logic            wr_en;
  logic            rd_en;
  logic            burst_end;
  logic [DW-1:0]   wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner_reg),
    .win         (win),
    .any         (any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = OW'(i);
    end
  end

  assign full  = (count_reg == CW'(CAPACITY));
  assign empty = (count_reg == '0);

  // A write while full stays blocked even if a read frees a slot this cycle.
  assign wr_en     = (state_reg == BURST) && req[owner_reg] && !full;
  assign rd_en     = rd_req && !empty;
  assign burst_end = (state_reg == BURST) &&
                     ((wr_en && (beat_cnt_reg == BW'(MAX_BURST - 1))) || !req[owner_reg]);

  assign count_next = count_reg + CW'(wr_en) - CW'(rd_en);

  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    owner_next       = owner_reg;
    beat_cnt_next    = beat_cnt_reg;
    last_winner_next = last_winner_reg;
    case (state_reg)
      IDLE: begin
        if (any) begin
          state_next    = BURST;
          gnt_next      = win;
          owner_next    = win_idx;
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        if (wr_en) beat_cnt_next = beat_cnt_reg + 1'b1;
        if (burst_end) begin
          state_next       = IDLE;
          gnt_next         = '0;
          last_winner_next = owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      owner_reg       <= '0;
      beat_cnt_reg    <= '0;
      count_reg       <= '0;
      last_winner_reg <= OW'(NREQ - 1);
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      owner_reg       <= owner_next;
      beat_cnt_reg    <= beat_cnt_next;
      count_reg       <= count_next;
      last_winner_reg <= last_winner_next;
    end
  end

  assign gnt      = gnt_reg;
  assign ack      = wr_en;
  assign fifo_w   = wr_en;
  assign fifo_r   = rd_en;
  assign rd_ack   = rd_en;
  assign count    = count_reg;
  assign fifo_din = (|gnt_reg) ? wdata_arr[owner_reg] : '0;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_reg <= CW'(CAPACITY));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner-case sequences
// and a randomized run against a behavioural model, plus a FIFO data model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int CAP  = 31;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic            ack;
  logic            rd_req;
  logic            rd_ack;
  logic            fifo_w;
  logic [DW-1:0]   fifo_din;
  logic            fifo_r;
  logic [4:0]      count;
  logic            full;
  logic            empty;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .CAPACITY  (CAP),
    .MAX_BURST (MAXB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .ack      (ack),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .fifo_w   (fifo_w),
    .fifo_din (fifo_din),
    .fifo_r   (fifo_r),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Stand-in for the FIFO: first-word-fall-through queue driven by the pins.
  logic [7:0] fq[$];
  always @(posedge clk or negedge rst) begin
    if (!rst) fq.delete();
    else begin
      if (fifo_r && fq.size() > 0) void'(fq.pop_front());
      if (fifo_w) fq.push_back(fifo_din);
    end
  end

  function automatic logic [7:0] dout();
    return (fq.size() > 0) ? fq[0] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who owns the port, beats delivered, last winner, fill level.
  int m_busy, m_owner, m_beats, m_last, m_count;

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_last = NREQ - 1; m_count = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '1; rd_req = 1'b1; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_fifo_w", fifo_w, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_fifo_r", fifo_r, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_din", fifo_din, 0);
    req = '0; rd_req = 1'b0;
    rst = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rd;
    logic [3:0] gnt;
    logic       ack;
    logic       rd_ack;
    logic [4:0] count;
  } vec_t;

  vec_t tbl[12];
  int   order[8];
  int   beats[8];
  int   nb;
  logic [3:0] prev_gnt;
  logic found;
  logic [3:0] e_gnt;
  logic e_full, e_empty, e_ack, e_rd;
  logic [7:0] e_din;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; rd_req = 1'b0; wdata = '0;
    #1;

    // Single requester, 6 beats, then two reads.
    tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd0};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 5'd0};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 5'd1};
    tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 5'd2};
    tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 5'd3};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd4};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 5'd4};
    tbl[7]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 5'd5};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 5'd6};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd6};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 5'd6};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd5};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; rd_req = tbl[i].rd; wdata = {4{8'(8'h30 + i)}};
      @(negedge clk);
      $display("[TB] vec %0d req=%b rd=%b gnt=%b ack=%b rd_ack=%b count=%0d",
               i, req, rd_req, gnt, ack, rd_ack, count);
      chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
      chk($sformatf("vec%0d_rd_ack", i), rd_ack, tbl[i].rd_ack);
      chk($sformatf("vec%0d_count", i), count, tbl[i].count);
      chk($sformatf("vec%0d_full", i), full, tbl[i].count == 5'd31);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].count == 5'd0);
      tick();
    end

    // All four requesting: grants rotate 0,1,2,3,0 with 4 beats each.
    do_reset();
    req = 4'hF; nb = 0; prev_gnt = '0;
    for (int i = 0; i < 8; i++) begin order[i] = 0; beats[i] = 0; end
    for (int c = 0; c < 30; c++) begin
      wdata = $urandom;
      @(negedge clk);
      if (gnt != 0 && prev_gnt == 0) begin
        if (nb < 8) order[nb] = int'(gnt);
        nb++;
        $display("[TB] rr grant %0d gnt=%b", nb, gnt);
      end
      if (gnt != 0 && ack && nb > 0 && nb <= 8) beats[nb-1]++;
      prev_gnt = gnt;
      tick();
    end
    chk("rr_burst_count", nb, 6);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_order%0d", k), order[k], 1 << (k % 4));
      chk($sformatf("rr_beats%0d", k), beats[k], MAXB);
    end

    // Fill to capacity, stall, then one read frees a slot.
    do_reset();
    req = 4'b0001; found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      wdata = $urandom;
      @(negedge clk);
      if (count == 5'd31) found = 1'b1;
      else tick();
    end
    chk("fill_reached", found, 1);
    $display("[TB] fill count=%0d full=%b gnt=%b ack=%b", count, full, gnt, ack);
    chk("fill_full", full, 1);
    chk("fill_ack", ack, 0);
    chk("fill_fifo_w", fifo_w, 0);
    chk("fill_gnt_held", gnt, 4'b0001);
    tick();
    @(negedge clk);
    chk("stall_gnt_held", gnt, 4'b0001);
    chk("stall_ack", ack, 0);
    tick();
    rd_req = 1'b1;
    @(negedge clk);
    $display("[TB] read at full rd_ack=%b ack=%b count=%0d", rd_ack, ack, count);
    chk("fullrd_rd_ack", rd_ack, 1);
    chk("fullrd_fifo_r", fifo_r, 1);
    chk("fullrd_wr_blocked", ack, 0);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("after_rd_count", count, 30);
    chk("after_rd_ack", ack, 1);
    chk("after_rd_full", full, 0);
    tick();
    @(negedge clk);
    chk("refill_count", count, 31);
    tick();

    // Read while empty is gated; a written byte is read back next cycle.
    do_reset();
    rd_req = 1'b1;
    @(negedge clk);
    chk("empty_rd_ack", rd_ack, 0);
    chk("empty_fifo_r", fifo_r, 0);
    tick();
    @(negedge clk);
    chk("empty_count", count, 0);
    tick();
    rd_req = 1'b0; req = 4'b0001; wdata = 32'h000000A5;
    @(negedge clk);
    chk("a5_idle_gnt", gnt, 0);
    tick();
    @(negedge clk);
    chk("a5_ack", ack, 1);
    chk("a5_din", fifo_din, 8'hA5);
    tick();
    req = 4'b0000; rd_req = 1'b1;
    @(negedge clk);
    $display("[TB] readback rd_ack=%b dout=0x%0h count=%0d", rd_ack, dout(), count);
    chk("a5_rd_ack", rd_ack, 1);
    chk("a5_dout", dout(), 8'hA5);
    chk("a5_count", count, 1);
    tick();
    rd_req = 1'b0;

    // Asynchronous reset in the middle of a burst at count 10.
    do_reset();
    req = 4'b0100; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      wdata = $urandom;
      @(negedge clk);
      if (count == 5'd10) found = 1'b1;
      else tick();
    end
    chk("midrst_reached", found, 1);
    chk("midrst_gnt_before", gnt, 4'b0100);
    chk("midrst_ack_before", ack, 1);
    rst = 1'b0;
    #1;
    $display("[TB] mid-burst reset gnt=%b count=%0d ack=%b", gnt, count, ack);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_empty", empty, 1);
    @(posedge clk);
    #1;
    rst = 1'b1; req = 4'hF;
    @(negedge clk);
    chk("midrst_idle", gnt, 0);
    tick();
    @(negedge clk);
    chk("midrst_next_gnt", gnt, 4'b0001);
    tick();

    // Randomized traffic against the behavioural model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < NREQ; r++) if ($urandom_range(7) == 0) req[r] = ~req[r];
      rd_req = ($urandom_range(99) < ((c < 250) ? 25 : 70));
      wdata  = $urandom;
      @(negedge clk);
      e_gnt   = m_busy ? 4'(1 << m_owner) : 4'h0;
      e_full  = (m_count == CAP);
      e_empty = (m_count == 0);
      e_ack   = (m_busy != 0) && req[m_owner] && !e_full;
      e_rd    = rd_req && !e_empty;
      e_din   = m_busy ? wdata[m_owner*DW +: DW] : 8'h00;
      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_ack", ack, e_ack);
      chk("rnd_fifo_w", fifo_w, e_ack);
      chk("rnd_rd_ack", rd_ack, e_rd);
      chk("rnd_fifo_r", fifo_r, e_rd);
      chk("rnd_count", count, m_count);
      chk("rnd_full", full, e_full);
      chk("rnd_empty", empty, e_empty);
      chk("rnd_din", fifo_din, e_din);
      m_count = m_count + int'(e_ack) - int'(e_rd);
      if (m_busy != 0) begin
        if (e_ack) m_beats++;
        if (m_beats == MAXB || !req[m_owner]) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          int cand;
          cand = (m_last + k) % NREQ;
          if (m_busy == 0 && req[cand]) begin
            m_busy = 1; m_owner = cand; m_beats = 0;
            $display("[TB] rnd cycle %0d grant to %0d count=%0d", c, cand, m_count);
          end
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write-side controller for the shared 32-entry, 8-bit FIFO.
- Arbitrates NREQ requesters for the single FIFO write port and grants each one a burst of up to MAX_BURST beats.
- Gates consumer reads.
- The FIFO exports no full/empty flags, so this block keeps its own occupancy count. It drives the FIFO's write-enable, data-in and read-enable pins directly.

## Interface
Parameters:
- NREQ, 4: number of write requesters (2..8)
- DW, 8: data width; must match the FIFO
- CAPACITY, 31: usable FIFO entries (32-slot ring, one slot always empty)
- MAX_BURST, 4: maximum beats per grant (1..16)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  NREQ  per-requester write request; held while the requester has data
- wdata  input  NREQ*DW  requester data, slice i = wdata[i*DW +: DW]
- gnt  output  NREQ  one-hot registered grant; all-zero when idle
- ack  output  1  beat accepted this cycle by the granted requester
- rd_req  input  1  consumer read request
- rd_ack  output  1  read performed this cycle; FIFO dout is valid in the same cycle
- fifo_w  output  1  to FIFO w_pin
- fifo_din  output  DW  to FIFO din
- fifo_r  output  1  to FIFO r_pin
- count  output  5  current occupancy, 0..CAPACITY
- full  output  1  count == CAPACITY
- empty  output  1  count == 0

## Operation
- States: IDLE, BURST.
- IDLE:
  - If any req is high, rr_pick selects the first requester after last_winner, wrapping.
  - Next cycle: gnt is one-hot for the winner, owner is registered, beat_cnt=0, state goes to BURST.
  - If no req is high, stay in IDLE.
- BURST:
  - fifo_w = ack = req[owner] && !full.
  - fifo_din = wdata slice for owner, and is driven whenever gnt is nonzero.
  - On ack, beat_cnt increments.
  - Burst ends when either (ack && beat_cnt == MAX_BURST-1) or !req[owner]. At the end: state goes to IDLE, gnt goes to 0, last_winner becomes owner.
  - A full FIFO stalls the burst: gnt stays held, no beat is written, and the burst does not end while req[owner] stays high.
- Read side: fifo_r = rd_ack = rd_req && !empty. This is combinational and independent of arbitration.
- Occupancy: count_next = count + fifo_w - fifo_r.
  - Simultaneous write and read leaves count unchanged.
  - A write while full is blocked even if a read happens in the same cycle. This matches the FIFO's pointer-based full check.
- last_winner resets to NREQ-1, so requester 0 has the highest priority after reset.
- The requester advances its data only on a cycle where gnt[i] && ack.

## Timing
- Reset values: state=IDLE, gnt=0, ack=0, fifo_w=0, fifo_r=0, rd_ack=0, count=0, empty=1, full=0, fifo_din=0.
- Reset mid-burst:
  - All state clears immediately (asynchronous).
  - Any beat in flight is lost.
  - The FIFO must be reset in the same cycle by the top level, which inverts rst for the FIFO's active-high reset.
- Latency:
  - req rising in IDLE at cycle N gives gnt at N+1; the first beat can be accepted at N+1.
  - Each burst is followed by one IDLE cycle, so the minimum gap between bursts is 1 cycle.
  - Full-rate aggregate throughput with 4-beat bursts is 4/5.
- gnt, owner, beat_cnt, count and last_winner are registered.
- ack, fifo_w, fifo_r, rd_ack, full and empty are combinational from registered state and inputs.
- count is a 5-bit value and never exceeds CAPACITY. It must not wrap; an assertion checks this.

## Structure
- Package fifo_arb_pkg contains:
  - typedef enum logic {IDLE, BURST} arb_state_t
  - localparam FIFO_DEPTH=32
  - localparam CAPACITY=FIFO_DEPTH-1
  - the count width as $clog2(FIFO_DEPTH)
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ] and last_winner.
  - Outputs: one-hot win and any.
- The top level (outside this block) instantiates fifo_wr_arbiter next to the FIFO.

## Test plan
- Reset, then req=0001 held with 6 beats: gnt=0001 at cycle 1, 4 acks, one IDLE cycle, regrant, 2 more acks. count=6 at the end.
- req=1111 held continuously: grants go to 0,1,2,3,0 in order, each for 4 beats. No requester is granted twice before all others have been granted once.
- Fill to 31 with no reads: full=1 and ack=0 while gnt stays held. Then rd_req for 1 cycle: rd_ack=1 and count=30. The next cycle ack=1 and count=31.
- count=31, write and read in the same cycle: write is blocked, read happens, count=30.
- count=0 with rd_req=1: rd_ack=0, fifo_r=0, count stays 0. Then write 0xA5 and read the next cycle: dout=0xA5 with rd_ack=1.
- Drop rst during beat 2 of a burst at count=10: gnt=0, count=0, state=IDLE, and the next grant goes to requester 0.
